strip_id_selector: RTL and testbench
====================================

// Module: strip_id_selector
// PURPOSE
//  Height-to-strip-ID lookup with a candidate-offer sequencer.
//  - Each height maps to a programmable table entry of NUM_CAND prioritised strip IDs.
//  - Valid candidates are offered one at a time, in priority order, to the strip allocator.
//  - The allocator accepts or rejects each offer; rejected candidates advance to the next valid one.
//  - The block reports the final allocated ID, or failure, to the placement controller.
// PARAMETERS
//  ID_W        4      strip ID width
//  NUM_CAND    3      candidates per entry; cand0 = highest priority, in the entry MS field
//  DEPTH       10     table entries; entry k serves height H_MIN+k
//  H_W         5      request height width
//  H_MIN       4      lowest supported height
//  INVALID_ID  4'hD   code marking an empty candidate slot
//  INIT_TABLE  {12'hABC,12'h8DD,12'h68D,12'h46D,12'h24D,12'h012,12'h301,12'h53D,12'h75D,12'h97D}
//              reset table contents; DEPTH*NUM_CAND*ID_W bits, entry 0 in the LSBs
// PORTS
//  clk         in   1               clock, rising edge
//  rst_n       in   1               asynchronous active-low reset
//  req_valid   in   1               height request valid
//  req_ready   out  1               high when state==IDLE
//  req_height  in   H_W             requested height
//  cand_valid  out  1               candidate offer valid
//  cand_ready  in   1               allocator takes the offer
//  cand_id     out  ID_W            offered strip ID
//  cand_rank   out  max(1,clog2(NUM_CAND))  priority index of the offer
//  fb_valid    in   1               allocator verdict valid
//  fb_accept   in   1               1 = accepted, 0 = rejected
//  done_valid  out  1               one-cycle result pulse
//  done_id     out  ID_W            accepted ID; INVALID_ID on failure
//  done_fail   out  1               no candidate accepted
//  busy        out  1               state != IDLE
//  cfg_we      in   1               table write strobe
//  cfg_addr    in   clog2(DEPTH)    entry index
//  cfg_data    in   NUM_CAND*ID_W   entry contents
// BEHAVIOUR
//  - Reset: state IDLE; table = INIT_TABLE; cand_valid, cand_id, cand_rank, done_valid, done_fail = 0.
//    done_id resets to INVALID_ID; busy = 0. Reset mid-operation aborts silently with no done pulse.
//  - States: IDLE -> LOOKUP -> OFFER <-> WAIT_FB -> DONE -> IDLE.
//  - IDLE: on req_valid&&req_ready, capture req_height and go to LOOKUP.
//  - LOOKUP (1 cycle): index = req_height-H_MIN. Heights above H_MIN+DEPTH-1 clamp to DEPTH-1.
//    - Latch the entry and set the remaining-mask bit i = (cand i != INVALID_ID).
//    - If height < H_MIN or the mask is empty: go to DONE with fail, and never assert cand_valid.
//  - OFFER: cand_valid=1; cand_id/cand_rank = lowest-index set bit of the remaining mask.
//    - Outputs stay stable until cand_ready; on the handshake go to WAIT_FB.
//    - cand_valid rises exactly 2 edges after the request handshake.
//  - WAIT_FB: cand_valid=0; fb_* is sampled only in this state and ignored elsewhere.
//    - On accept: go to DONE with done_id = offered ID.
//    - On reject: clear that mask bit. Any bit left -> OFFER on the next edge; else DONE with fail.
//    - Skipping INVALID slots costs no cycles.
//  - DONE: done_valid=1 for exactly 1 cycle (with done_id/done_fail), then IDLE.
//  - Table write: cfg_we writes entry cfg_addr at the edge; writes with cfg_addr >= DEPTH are ignored.
//    - Writes are allowed in any state; an entry already latched is unaffected.
//    - A write and a LOOKUP to the same entry in the same cycle: LOOKUP sees the old value.
// TESTING
//  1 Post-reset, height 8 (entry 12'h012): offer 0 rank0, accept -> done_id=0, done_fail=0.
//  2 Height 7 (12'h301): offers 3,0,1, reject each -> done_fail=1, done_id=4'hD.
//  3 Height 4 (12'h97D): offers 9,7, reject both -> fail with no third offer.
//    Height 12 (12'h8DD): a single offer 8.
//  4 Height 15 clamps to entry 12'hABC: offer A; height 3 -> done_fail with no cand_valid.
//  5 cand_ready held 0 for 5 cycles in OFFER: cand_valid, cand_id, cand_rank stay stable.
//    fb_valid pulsed in OFFER is ignored.
//  6 Write entry 0 = 12'hDDD, then height 4 -> immediate fail.
//    rst_n low in WAIT_FB -> outputs at reset values, req_ready=1, no done pulse.

Source files
------------

// File: rtl/strip_id_selector_if.sv
// Bus bundle for strip_id_selector: request, candidate offer, allocator verdict,
// result and table-programming signals. clk/rst_n stay outside the bundle.
interface strip_id_selector_if #(
    parameter int ID_W    = 4,
    parameter int H_W     = 5,
    parameter int RANK_W  = 2,
    parameter int ADDR_W  = 4,
    parameter int ENTRY_W = 12
);
    logic               req_valid;
    logic               req_ready;
    logic [H_W-1:0]     req_height;
    logic               cand_valid;
    logic               cand_ready;
    logic [ID_W-1:0]    cand_id;
    logic [RANK_W-1:0]  cand_rank;
    logic               fb_valid;
    logic               fb_accept;
    logic               done_valid;
    logic [ID_W-1:0]    done_id;
    logic               done_fail;
    logic               busy;
    logic               cfg_we;
    logic [ADDR_W-1:0]  cfg_addr;
    logic [ENTRY_W-1:0] cfg_data;

    modport slave (
        input  req_valid, req_height, cand_ready, fb_valid, fb_accept,
               cfg_we, cfg_addr, cfg_data,
        output req_ready, cand_valid, cand_id, cand_rank,
               done_valid, done_id, done_fail, busy
    );

    modport master (
        output req_valid, req_height, cand_ready, fb_valid, fb_accept,
               cfg_we, cfg_addr, cfg_data,
        input  req_ready, cand_valid, cand_id, cand_rank,
               done_valid, done_id, done_fail, busy
    );
endinterface

// File: rtl/strip_id_selector.sv
// Height-to-strip-ID lookup: a programmable table of prioritised candidates per height,
// offered one at a time to the strip allocator until one is accepted or all are rejected.
module strip_id_selector #(
    parameter int ID_W     = 4,
    parameter int NUM_CAND = 3,
    parameter int DEPTH    = 10,
    parameter int H_W      = 5,
    parameter int H_MIN    = 4,
    parameter logic [ID_W-1:0] INVALID_ID = 4'hD,
    parameter logic [DEPTH*NUM_CAND*ID_W-1:0] INIT_TABLE = {
        12'hABC, 12'h8DD, 12'h68D, 12'h46D, 12'h24D,
        12'h012, 12'h301, 12'h53D, 12'h75D, 12'h97D}
) (
    input  logic               clk,
    input  logic               rst_n,
    strip_id_selector_if.slave bus
);
    localparam int ENTRY_W = NUM_CAND * ID_W;
    localparam int RANK_W  = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1;
    localparam int ADDR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_OFFER, S_WAIT_FB, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [H_W-1:0]      height_q, height_d;
    logic [ENTRY_W-1:0]  entry_q, entry_d;
    logic [NUM_CAND-1:0] mask_q, mask_d;
    logic                cand_valid_q, cand_valid_d;
    logic [ID_W-1:0]     cand_id_q, cand_id_d;
    logic [RANK_W-1:0]   cand_rank_q, cand_rank_d;
    logic                done_valid_q, done_valid_d;
    logic [ID_W-1:0]     done_id_q, done_id_d;
    logic                done_fail_q, done_fail_d;

    logic [ENTRY_W-1:0]  table_q [DEPTH];

    // Table is reloaded from INIT_TABLE by reset; out-of-range writes are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) table_q[i] <= INIT_TABLE[i*ENTRY_W +: ENTRY_W];
        end else if (bus.cfg_we && (int'(bus.cfg_addr) < DEPTH)) begin
            table_q[bus.cfg_addr] <= bus.cfg_data;
        end
    end

    logic [H_W-1:0]      h_off;
    logic                height_low;
    logic [ADDR_W-1:0]   lookup_idx;
    logic [ENTRY_W-1:0]  lookup_entry;
    logic [NUM_CAND-1:0] lookup_mask;

    always_comb begin
        h_off      = height_q - H_W'(H_MIN);
        height_low = (height_q < H_W'(H_MIN));
        if (height_low)                             lookup_idx = '0;
        else if (height_q > H_W'(H_MIN + DEPTH - 1)) lookup_idx = ADDR_W'(DEPTH - 1);
        else                                        lookup_idx = ADDR_W'(h_off);
        lookup_entry = table_q[lookup_idx];
        for (int i = 0; i < NUM_CAND; i++)
            lookup_mask[i] = (lookup_entry[(NUM_CAND-1-i)*ID_W +: ID_W] != INVALID_ID);
    end

    logic [NUM_CAND-1:0] reject_mask;
    always_comb begin
        for (int i = 0; i < NUM_CAND; i++)
            reject_mask[i] = mask_q[i] && (cand_rank_q != RANK_W'(i));
    end

    // Next offer comes from the freshly looked-up entry or from the post-reject mask.
    logic [NUM_CAND-1:0] src_mask;
    logic [ENTRY_W-1:0]  src_entry;
    logic [RANK_W-1:0]   enc_rank;
    logic [ID_W-1:0]     enc_id;

    always_comb begin
        src_mask  = (state_q == S_LOOKUP) ? lookup_mask  : reject_mask;
        src_entry = (state_q == S_LOOKUP) ? lookup_entry : entry_q;
        enc_rank  = '0;
        enc_id    = src_entry[ENTRY_W-1 -: ID_W];
        for (int i = NUM_CAND - 1; i >= 0; i--) begin
            if (src_mask[i]) begin
                enc_rank = RANK_W'(i);
                enc_id   = src_entry[(NUM_CAND-1-i)*ID_W +: ID_W];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        height_d     = height_q;
        entry_d      = entry_q;
        mask_d       = mask_q;
        cand_valid_d = cand_valid_q;
        cand_id_d    = cand_id_q;
        cand_rank_d  = cand_rank_q;
        done_valid_d = 1'b0;
        done_id_d    = done_id_q;
        done_fail_d  = done_fail_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    height_d = bus.req_height;
                    state_d  = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                entry_d = lookup_entry;
                mask_d  = height_low ? '0 : lookup_mask;
                if (height_low || (lookup_mask == '0)) begin
                    state_d      = S_DONE;
                    done_valid_d = 1'b1;
                    done_id_d    = INVALID_ID;
                    done_fail_d  = 1'b1;
                end else begin
                    state_d      = S_OFFER;
                    cand_valid_d = 1'b1;
                    cand_id_d    = enc_id;
                    cand_rank_d  = enc_rank;
                end
            end
            S_OFFER: begin
                if (bus.cand_ready) begin
                    cand_valid_d = 1'b0;
                    state_d      = S_WAIT_FB;
                end
            end
            S_WAIT_FB: begin
                if (bus.fb_valid) begin
                    if (bus.fb_accept) begin
                        state_d      = S_DONE;
                        done_valid_d = 1'b1;
                        done_id_d    = cand_id_q;
                        done_fail_d  = 1'b0;
                    end else begin
                        mask_d = reject_mask;
                        if (reject_mask != '0) begin
                            state_d      = S_OFFER;
                            cand_valid_d = 1'b1;
                            cand_id_d    = enc_id;
                            cand_rank_d  = enc_rank;
                        end else begin
                            state_d      = S_DONE;
                            done_valid_d = 1'b1;
                            done_id_d    = INVALID_ID;
                            done_fail_d  = 1'b1;
                        end
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            height_q     <= '0;
            entry_q      <= '0;
            mask_q       <= '0;
            cand_valid_q <= 1'b0;
            cand_id_q    <= '0;
            cand_rank_q  <= '0;
            done_valid_q <= 1'b0;
            done_id_q    <= INVALID_ID;
            done_fail_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            height_q     <= height_d;
            entry_q      <= entry_d;
            mask_q       <= mask_d;
            cand_valid_q <= cand_valid_d;
            cand_id_q    <= cand_id_d;
            cand_rank_q  <= cand_rank_d;
            done_valid_q <= done_valid_d;
            done_id_q    <= done_id_d;
            done_fail_q  <= done_fail_d;
        end
    end

    assign bus.req_ready  = (state_q == S_IDLE);
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.cand_valid = cand_valid_q;
    assign bus.cand_id    = cand_id_q;
    assign bus.cand_rank  = cand_rank_q;
    assign bus.done_valid = done_valid_q;
    assign bus.done_id    = done_id_q;
    assign bus.done_fail  = done_fail_q;
endmodule

// File: tb/tb_strip_id_selector.sv
// Bench for strip_id_selector: directed vector table, hand-written corner sequences and
// randomised transactions against a candidate-list model of the lookup table.
module tb_strip_id_selector;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    strip_id_selector_if #(.ID_W(4), .H_W(5), .RANK_W(2), .ADDR_W(4), .ENTRY_W(12)) bus();

    strip_id_selector dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    localparam logic [119:0] INIT = {12'hABC, 12'h8DD, 12'h68D, 12'h46D, 12'h24D,
                                     12'h012, 12'h301, 12'h53D, 12'h75D, 12'h97D};

    int checks = 0;
    int errors = 0;
    logic [11:0] mtbl [10];

    typedef struct {
        int h; int acc; int rdy; int fbd;
        int exp_first; int exp_id; int exp_fail;
    } vec_t;
    vec_t vecs [8];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        logic [119:0] init_v;
        init_v = INIT;
        for (int k = 0; k < 10; k++) mtbl[k] = init_v[k*12 +: 12];
    endtask

    task automatic cfg_write(input int addr, input logic [11:0] data);
        @(negedge clk);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = addr[3:0];
        bus.cfg_data = data;
        @(negedge clk);
        bus.cfg_we = 1'b0;
        if (addr < 10) mtbl[addr] = data;
        $display("cfg write addr=%0d data=%03h", addr, data);
    endtask

    // acc_at: offer number to accept (-1 rejects everything).
    task automatic run_txn(input int h, input int acc_at, input int rdy_dly, input int fb_dly,
                           input bit fb_in_offer, input bit wr_lookup, input logic [11:0] wr_data,
                           output int first_id, output int done_id, output int done_fail);
        int ids[$];
        int ranks[$];
        int idx;
        int n_exp;
        int exp_id;
        int exp_fail;
        int c;
        idx = 0;
        if (h >= 4) begin
            idx = (h - 4 > 9) ? 9 : h - 4;
            for (int i = 0; i < 3; i++) begin
                c = int'((mtbl[idx] >> ((2 - i) * 4)) & 12'hF);
                if (c != 13) begin ids.push_back(c); ranks.push_back(i); end
            end
        end
        if (acc_at >= 0 && acc_at < ids.size()) begin
            n_exp = acc_at + 1; exp_id = ids[acc_at]; exp_fail = 0;
        end else begin
            n_exp = ids.size(); exp_id = 13; exp_fail = 1;
        end
        first_id = -1;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_height = h[4:0];
        chk("req_ready_idle", int'(bus.req_ready), 1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("lookup_no_offer", int'(bus.cand_valid), 0);
        chk("lookup_busy", int'(bus.busy), 1);
        if (wr_lookup) begin
            bus.cfg_we = 1'b1; bus.cfg_addr = idx[3:0]; bus.cfg_data = wr_data;
        end
        @(negedge clk);
        bus.cfg_we = 1'b0;
        if (wr_lookup) mtbl[idx] = wr_data;
        for (int k = 0; k < n_exp; k++) begin
            chk("offer_valid", int'(bus.cand_valid), 1);
            chk("offer_id", int'(bus.cand_id), ids[k]);
            chk("offer_rank", int'(bus.cand_rank), ranks[k]);
            if (k == 0) first_id = int'(bus.cand_id);
            for (int d = 0; d < rdy_dly; d++) begin
                if (fb_in_offer && d == 0) begin bus.fb_valid = 1'b1; bus.fb_accept = 1'b1; end
                @(negedge clk);
                bus.fb_valid = 1'b0; bus.fb_accept = 1'b0;
                chk("hold_valid", int'(bus.cand_valid), 1);
                chk("hold_id", int'(bus.cand_id), ids[k]);
                chk("hold_rank", int'(bus.cand_rank), ranks[k]);
            end
            bus.cand_ready = 1'b1;
            @(negedge clk);
            bus.cand_ready = 1'b0;
            chk("wait_fb_no_offer", int'(bus.cand_valid), 0);
            for (int d = 0; d < fb_dly; d++) begin
                @(negedge clk);
                chk("wait_fb_no_offer", int'(bus.cand_valid), 0);
                chk("wait_fb_no_done", int'(bus.done_valid), 0);
            end
            bus.fb_valid  = 1'b1;
            bus.fb_accept = (k == acc_at);
            @(negedge clk);
            bus.fb_valid = 1'b0; bus.fb_accept = 1'b0;
        end
        chk("done_valid", int'(bus.done_valid), 1);
        chk("done_id", int'(bus.done_id), exp_id);
        chk("done_fail", int'(bus.done_fail), exp_fail);
        chk("done_no_offer", int'(bus.cand_valid), 0);
        done_id   = int'(bus.done_id);
        done_fail = int'(bus.done_fail);
        @(negedge clk);
        chk("done_pulse_end", int'(bus.done_valid), 0);
        chk("back_idle", int'(bus.req_ready), 1);
        $display("txn h=%0d acc_at=%0d offers=%0d first=%0d done_id=%0d fail=%0d",
                 h, acc_at, n_exp, first_id, done_id, done_fail);
    endtask

    int f, di, df;
    logic [11:0] rd;

    initial begin
        bus.req_valid = 1'b0; bus.req_height = '0; bus.cand_ready = 1'b0;
        bus.fb_valid = 1'b0; bus.fb_accept = 1'b0;
        bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
        model_reset();

        vecs[0] = '{8,  0, 0, 0,  0,  0, 0};
        vecs[1] = '{7, -1, 1, 0,  3, 13, 1};
        vecs[2] = '{4, -1, 0, 2,  9, 13, 1};
        vecs[3] = '{12, -1, 0, 0, 8, 13, 1};
        vecs[4] = '{15, 0, 2, 1, 10, 10, 0};
        vecs[5] = '{3,  0, 0, 0, -1, 13, 1};
        vecs[6] = '{5,  1, 0, 1,  7,  5, 0};
        vecs[7] = '{31, 2, 1, 0, 10, 12, 0};

        repeat (2) @(negedge clk);
        chk("rst_req_ready", int'(bus.req_ready), 1);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_cand_valid", int'(bus.cand_valid), 0);
        chk("rst_cand_id", int'(bus.cand_id), 0);
        chk("rst_cand_rank", int'(bus.cand_rank), 0);
        chk("rst_done_valid", int'(bus.done_valid), 0);
        chk("rst_done_id", int'(bus.done_id), 13);
        chk("rst_done_fail", int'(bus.done_fail), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i].h, vecs[i].acc, vecs[i].rdy, vecs[i].fbd, 1'b0, 1'b0, 12'h0, f, di, df);
            chk($sformatf("vec%0d_first", i), f, vecs[i].exp_first);
            chk($sformatf("vec%0d_done_id", i), di, vecs[i].exp_id);
            chk($sformatf("vec%0d_fail", i), df, vecs[i].exp_fail);
        end

        // Stall in OFFER with a stray verdict pulse that must be ignored.
        run_txn(9, 0, 5, 1, 1'b1, 1'b0, 12'h0, f, di, df);
        chk("stall_done_id", di, 2);

        // Table writes: empty entry 0, ignored out-of-range address.
        cfg_write(0, 12'hDDD);
        cfg_write(12, 12'h111);
        run_txn(4, 0, 0, 0, 1'b0, 1'b0, 12'h0, f, di, df);
        chk("empty_entry_first", f, -1);
        chk("empty_entry_fail", df, 1);
        run_txn(13, 0, 0, 0, 1'b0, 1'b0, 12'h0, f, di, df);
        chk("oob_write_ignored", di, 10);

        // Write coinciding with LOOKUP of the same entry: old value used, new one next time.
        run_txn(8, 0, 0, 0, 1'b0, 1'b1, 12'h5DD, f, di, df);
        chk("wr_lookup_old", di, 0);
        run_txn(8, 0, 0, 0, 1'b0, 1'b0, 12'h0, f, di, df);
        chk("wr_lookup_new", di, 5);

        // Reset while waiting for the verdict.
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_height = 5'd7;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        bus.cand_ready = 1'b1;
        @(negedge clk);
        bus.cand_ready = 1'b0;
        chk("pre_reset_busy", int'(bus.busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_cand_valid", int'(bus.cand_valid), 0);
        chk("mid_rst_cand_id", int'(bus.cand_id), 0);
        chk("mid_rst_done_valid", int'(bus.done_valid), 0);
        chk("mid_rst_done_id", int'(bus.done_id), 13);
        chk("mid_rst_busy", int'(bus.busy), 0);
        chk("mid_rst_req_ready", int'(bus.req_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_done_after_reset", int'(bus.done_valid), 0);
        end
        $display("mid-operation reset applied");
        run_txn(4, -1, 0, 0, 1'b0, 1'b0, 12'h0, f, di, df);
        chk("table_restored", f, 9);

        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                for (int j = 0; j < 3; j++)
                    rd[j*4 +: 4] = ($urandom_range(0, 1) == 1) ? 4'hD : 4'($urandom_range(0, 15));
                cfg_write(int'($urandom_range(0, 15)), rd);
            end
            run_txn(int'($urandom_range(0, 31)), int'($urandom_range(0, 3)) - 1,
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                    1'($urandom_range(0, 1)), 1'b0, 12'h0, f, di, df);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
